// File: rtl/proc_inst_queue.sv
// proc_inst_queue: decoupling instruction queue between fetch (F) and
// decode (D) of the TinyRV1 processor. Holds {pc, inst} pairs in a small
// circular buffer and hands them to decode in FIFO order with val/rdy.
// A squash flushes every entry on a downstream redirect.
//
// Optional feature: define PROC_INST_QUEUE_BYPASS_EN to let an entry
// arriving at an empty queue be presented to decode in the same cycle.
// Without it, ready/valid come only from state and nothing on enq_*
// reaches deq_* combinationally.
module proc_inst_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_val,
  output logic                       enq_rdy,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_inst,
  output logic                       deq_val,
  input  logic                       deq_rdy,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_inst,
  input  logic                       squash,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Each entry packs the pc in the upper word and the instruction below it.
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic is_empty;
  logic is_full;
  logic bypass;
  logic wr_en;
  logic rd_en;

  // Full and empty are told apart only by the occupancy counter, because
  // the pointers look identical in both cases.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign enq_rdy  = ~is_full;
  assign count    = count_q;

`ifdef PROC_INST_QUEUE_BYPASS_EN
  // An empty queue may forward the incoming entry straight to decode.
  assign bypass = is_empty & enq_val & ~squash;
`else
  assign bypass = 1'b0;
`endif

  // An entry handed over through the bypass is consumed and never stored.
  // A squash discards whatever fetch offers in that cycle.
  assign wr_en = enq_val & enq_rdy & ~squash & ~(bypass & deq_rdy);
  assign rd_en = deq_rdy & ~is_empty;

  // Present the head entry, the bypassed entry, or zeros when nothing is valid.
  always_comb begin
    deq_val  = 1'b0;
    deq_pc   = 32'h0;
    deq_inst = 32'h0;
    if (!is_empty) begin
      deq_val  = 1'b1;
      deq_pc   = mem[rd_ptr][63:32];
      deq_inst = mem[rd_ptr][31:0];
    end else if (bypass) begin
      deq_val  = 1'b1;
      deq_pc   = enq_pc;
      deq_inst = enq_inst;
    end
  end

  // Storage array; contents carry no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {enq_pc, enq_inst};
    end
  end

  // Pointers and occupancy: reset beats squash, squash beats transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (squash) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_inst_queue.sv
// tb_proc_inst_queue: directed and randomized stimulus against an abstract
// FIFO model. The driver pushes each expected handoff into a scoreboard;
// a separate monitor pops and compares whenever decode accepts an entry.
module tb_proc_inst_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_val;
  logic          enq_rdy;
  logic [31:0]   enq_pc;
  logic [31:0]   enq_inst;
  logic          deq_val;
  logic          deq_rdy;
  logic [31:0]   deq_pc;
  logic [31:0]   deq_inst;
  logic          squash;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  // Reference contents of the queue, head at index 0.
  logic [63:0] mdl_q[$];
  // Entries expected to be handed to decode, in order.
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  proc_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enq_val  (enq_val),
    .enq_rdy  (enq_rdy),
    .enq_pc   (enq_pc),
    .enq_inst (enq_inst),
    .deq_val  (deq_val),
    .deq_rdy  (deq_rdy),
    .deq_pc   (deq_pc),
    .deq_inst (deq_inst),
    .squash   (squash),
    .count    (count)
  );

  function automatic bit bypass_on();
`ifdef PROC_INST_QUEUE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks visible state at the negedge and
  // advances the model at the following posedge.
  task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                               input logic dr, input logic sq, input logic r);
    logic        exp_dval;
    logic [63:0] exp_data;
    logic        byp;
    int          sz;
    enq_val  = ev;
    enq_pc   = pc;
    enq_inst = inst;
    deq_rdy  = dr;
    squash   = sq;
    rst      = r;
    sz  = mdl_q.size();
    byp = bypass_on() && (sz == 0) && ev && !sq;
    exp_dval = (sz != 0) || byp;
    exp_data = (sz != 0) ? mdl_q[0] : (byp ? {pc, inst} : 64'h0);
    if (!r && dr && exp_dval) exp_q.push_back(exp_data);
    @(negedge clk);
    checkOutput("enq_rdy",  64'(enq_rdy),  64'(sz != DEPTH));
    checkOutput("deq_val",  64'(deq_val),  64'(exp_dval));
    checkOutput("deq_pc",   64'(deq_pc),   64'(exp_data[63:32]));
    checkOutput("deq_inst", 64'(deq_inst), 64'(exp_data[31:0]));
    checkOutput("count",    64'(count),    64'(sz));
    @(posedge clk);
    if (r) begin
      mdl_q.delete();
    end else begin
      if (dr && sz != 0) void'(mdl_q.pop_front());
      if (sq) mdl_q.delete();
      else if (ev && sz < DEPTH && !(byp && dr)) mdl_q.push_back({pc, inst});
    end
    #1;
  endtask

  // Monitor: every accepted handoff must match the oldest expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && deq_val === 1'b1 && deq_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL deq_unexpected: got %h expected none at %0t", {deq_pc, deq_inst}, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("deq_stream", {deq_pc, deq_inst}, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enq_val = 1'b0; enq_pc = '0; enq_inst = '0; deq_rdy = 1'b0; squash = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_deq_val",  64'(deq_val),  64'h0);
    checkOutput("rst_enq_rdy",  64'(enq_rdy),  64'h1);
    checkOutput("rst_count",    64'(count),    64'h0);
    checkOutput("rst_deq_pc",   64'(deq_pc),   64'h0);
    checkOutput("rst_deq_inst", 64'(deq_inst), 64'h0);

    // Fill to capacity; the third offer must be refused.
    applyStimulus(1'b1, 32'h200, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h204, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h208, 32'h33, 1'b0, 1'b0, 1'b0);
    // Drain in order, then observe empty.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Streaming across pointer wrap.
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 32'h200 + 32'(4 * k), 32'h100 + 32'(k), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Squash with a concurrent offer that must be dropped.
    applyStimulus(1'b1, 32'h2f0, 32'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2f4, 32'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h300, 32'h66, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Empty queue with decode ready: same-cycle only when bypass is built in.
    applyStimulus(1'b1, 32'h400, 32'h77, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic including occasional squash and mid-run reset.
    for (int k = 0; k < 500; k++) begin
      logic ev, dr, sq, r;
      ev = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      sq = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 99) == 0);
      if (r) dr = 1'b0;
      applyStimulus(ev, 32'h1000 + 32'(4 * k), $urandom, dr, sq, r);
    end

    // Drain whatever is left, then confirm every expected handoff happened.
    for (int k = 0; k < DEPTH + 2; k++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
